// File: rtl/airi5c_ftoi_converter.sv
// Float-to-integer converter for FCVT.W.S / FCVT.WU.S.
// Three-cycle flow: load -> align significand -> round, saturate and flag.
module airi5c_ftoi_converter (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        kill,
    input  logic        load,
    input  logic        op_cvtfi,
    input  logic        op_cvtfu,
    input  logic [2:0]  rm,
    input  logic [31:0] float_in,
    output logic [31:0] int_out,
    output logic        NV,
    output logic        NX,
    output logic        ready
);

    typedef enum logic [1:0] {IDLE, ALIGN, ROUND} state_t;

    state_t      state;
    logic        sign_r;
    logic [7:0]  exp_r;
    logic [22:0] man_r;
    logic [2:0]  rm_r;
    logic        uns_r;
    logic [31:0] mag_r;
    logic        rnd_r;
    logic        stk_r;
    logic        nan_r;
    logic        inf_r;
    logic        ovf_r;

    logic [31:0] al_mag;
    logic        al_rnd;
    logic        al_stk;
    logic        al_nan;
    logic        al_inf;
    logic        al_ovf;
    logic [7:0]  sh_amt;
    logic [63:0] sig_ext;
    logic [63:0] shifted;

    // Significand sits at the top of a 64-bit word; after shifting right by
    // (31 - e) the upper half is the integer part and the lower half the fraction.
    always_comb begin
        al_mag  = '0;
        al_rnd  = 1'b0;
        al_stk  = 1'b0;
        al_nan  = 1'b0;
        al_inf  = 1'b0;
        al_ovf  = 1'b0;
        sh_amt  = 8'd158 - exp_r;
        sig_ext = {1'b1, man_r, 40'b0};
        shifted = '0;
        if (exp_r == 8'hFF) begin
            al_nan = |man_r;
            al_inf = ~|man_r;
        end else if (exp_r == 8'h00) begin
            al_stk = |man_r;
        end else if (exp_r < 8'd127) begin
            al_rnd = (exp_r == 8'd126);
            al_stk = (exp_r == 8'd126) ? |man_r : 1'b1;
        end else if (exp_r >= 8'd159) begin
            al_ovf = 1'b1;
        end else begin
            shifted = sig_ext >> sh_amt[4:0];
            al_mag  = shifted[63:32];
            al_rnd  = shifted[31];
            al_stk  = |shifted[30:0];
        end
    end

    logic        inexact;
    logic        inc;
    logic [32:0] rounded;
    logic        invalid;
    logic [31:0] result;

    always_comb begin
        inexact = rnd_r | stk_r;
        case (rm_r)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sign_r & inexact;
            3'b011:  inc = ~sign_r & inexact;
            3'b100:  inc = rnd_r;
            default: inc = rnd_r & (stk_r | mag_r[0]);
        endcase
        rounded = {1'b0, mag_r} + {32'b0, inc};
        invalid = 1'b0;
        result  = '0;
        if (nan_r) begin
            invalid = 1'b1;
            result  = uns_r ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (inf_r || ovf_r) begin
            invalid = 1'b1;
            if (sign_r)
                result = uns_r ? 32'h0000_0000 : 32'h8000_0000;
            else
                result = uns_r ? 32'hFFFF_FFFF : 32'h7FFF_FFFF;
        end else if (uns_r) begin
            if (sign_r) begin
                invalid = (rounded != 33'd0);
                result  = '0;
            end else if (rounded[32]) begin
                invalid = 1'b1;
                result  = 32'hFFFF_FFFF;
            end else begin
                result = rounded[31:0];
            end
        end else begin
            if (sign_r) begin
                if (rounded > 33'h0_8000_0000) begin
                    invalid = 1'b1;
                    result  = 32'h8000_0000;
                end else begin
                    result = -rounded[31:0];
                end
            end else if (rounded > 33'h0_7FFF_FFFF) begin
                invalid = 1'b1;
                result  = 32'h7FFF_FFFF;
            end else begin
                result = rounded[31:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset || kill || (load && !op_cvtfi && !op_cvtfu)) begin
            state   <= IDLE;
            sign_r  <= 1'b0;
            exp_r   <= '0;
            man_r   <= '0;
            rm_r    <= '0;
            uns_r   <= 1'b0;
            mag_r   <= '0;
            rnd_r   <= 1'b0;
            stk_r   <= 1'b0;
            nan_r   <= 1'b0;
            inf_r   <= 1'b0;
            ovf_r   <= 1'b0;
            int_out <= '0;
            NV      <= 1'b0;
            NX      <= 1'b0;
            ready   <= 1'b0;
        end else if (load) begin
            state  <= ALIGN;
            sign_r <= float_in[31];
            exp_r  <= float_in[30:23];
            man_r  <= float_in[22:0];
            rm_r   <= rm;
            uns_r  <= op_cvtfu & ~op_cvtfi;
            ready  <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                ALIGN: begin
                    mag_r <= al_mag;
                    rnd_r <= al_rnd;
                    stk_r <= al_stk;
                    nan_r <= al_nan;
                    inf_r <= al_inf;
                    ovf_r <= al_ovf;
                    state <= ROUND;
                end
                ROUND: begin
                    int_out <= result;
                    NV      <= invalid;
                    NX      <= ~invalid & inexact;
                    ready   <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_airi5c_ftoi_converter.sv
// Self-checking bench for airi5c_ftoi_converter: directed corner cases plus
// random operands compared against a real-arithmetic reference model.
module tb_airi5c_ftoi_converter;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        kill;
    logic        load;
    logic        op_cvtfi;
    logic        op_cvtfu;
    logic [2:0]  rm;
    logic [31:0] float_in;
    logic [31:0] int_out;
    logic        NV;
    logic        NX;
    logic        ready;

    int errors = 0;
    int checks = 0;

    airi5c_ftoi_converter dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .kill     (kill),
        .load     (load),
        .op_cvtfi (op_cvtfi),
        .op_cvtfu (op_cvtfu),
        .rm       (rm),
        .float_in (float_in),
        .int_out  (int_out),
        .NV       (NV),
        .NX       (NX),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Value-level model: exact magnitude as a real, then rounding by comparing the fraction.
    task automatic ref_model(input logic [31:0] f, input bit uns, input logic [2:0] r,
                             output logic [31:0] res, output bit nv, output bit nx);
        bit     s;
        int     ex;
        real    mag, ip, fr;
        longint ipl, rv, sv;
        bit     inc, inexact;
        s  = f[31];
        ex = int'(f[30:23]);
        nv = 0;
        nx = 0;
        res = 0;
        if (ex == 255) begin
            nv = 1;
            if (f[22:0] != 0 || !s) res = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
            else                    res = uns ? 32'h0 : 32'h80000000;
            return;
        end
        if (ex == 0) mag = real'(f[22:0]) * (2.0 ** (-149.0));
        else         mag = real'(32'h800000 + f[22:0]) * (2.0 ** (real'(ex) - 150.0));
        if (mag >= 8589934592.0) begin
            nv = 1;
            if (s) res = uns ? 32'h0 : 32'h80000000;
            else   res = uns ? 32'hFFFFFFFF : 32'h7FFFFFFF;
            return;
        end
        ip = $floor(mag);
        fr = mag - ip;
        ipl = longint'(ip);
        inexact = (fr != 0.0);
        case (r)
            3'd1:    inc = 0;
            3'd2:    inc = s && inexact;
            3'd3:    inc = !s && inexact;
            3'd4:    inc = (fr >= 0.5);
            default: inc = (fr > 0.5) || (fr == 0.5 && (ipl % 2 == 1));
        endcase
        rv = ipl + (inc ? 1 : 0);
        if (uns) begin
            if (s && rv != 0)          begin nv = 1; res = 0; end
            else if (rv > 64'hFFFFFFFF) begin nv = 1; res = 32'hFFFFFFFF; end
            else                       res = 32'(rv);
        end else begin
            sv = s ? -rv : rv;
            if (sv > 64'sd2147483647)       begin nv = 1; res = 32'h7FFFFFFF; end
            else if (sv < -64'sd2147483648) begin nv = 1; res = 32'h80000000; end
            else                            res = 32'(sv);
        end
        nx = !nv && inexact;
    endtask

    task automatic run_op(input string tag, input logic [31:0] f, input bit uns, input logic [2:0] r);
        logic [31:0] er;
        bit          env, enx;
        int          k;
        logic [31:0] held;
        ref_model(f, uns, r, er, env, enx);
        @(negedge clk);
        float_in = f; rm = r; op_cvtfi = !uns; op_cvtfu = uns; load = 1;
        @(negedge clk);
        load = 0; op_cvtfi = 0; op_cvtfu = 0; float_in = $urandom; rm = 3'($urandom);
        k = 0;
        while (!ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), 32'd2);
        chk({tag, "_int"}, int_out, er);
        chk({tag, "_nv"}, {31'b0, NV}, {31'b0, env});
        chk({tag, "_nx"}, {31'b0, NX}, {31'b0, enx});
        held = int_out;
        @(negedge clk);
        chk({tag, "_ready_drop"}, {31'b0, ready}, 32'd0);
        chk({tag, "_hold"}, int_out, er);
    endtask

    task automatic check_cleared(input string tag);
        int seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready) seen++;
        end
        chk({tag, "_no_ready"}, 32'(seen), 32'd0);
        chk({tag, "_out"}, {int_out[31:2], int_out[1:0] | {NV, NX}}, 32'd0);
    endtask

    initial begin
        n_reset = 0; kill = 0; load = 0; op_cvtfi = 0; op_cvtfu = 0; rm = 0; float_in = 0;
        repeat (2) @(negedge clk);
        chk("reset_int", int_out, 32'd0);
        chk("reset_flags", {29'b0, NV, NX, ready}, 32'd0);
        n_reset = 1;

        run_op("rne_2p5", 32'h40200000, 0, 3'd0);
        run_op("rup_2p5", 32'h40200000, 0, 3'd3);
        run_op("rmm_2p5", 32'h40200000, 0, 3'd4);
        run_op("rtz_2p5", 32'h40200000, 0, 3'd1);
        run_op("rdn_m2p5", 32'hC0200000, 0, 3'd2);
        run_op("rtz_m2p5", 32'hC0200000, 0, 3'd1);
        run_op("m10", 32'hC1200000, 0, 3'd0);
        run_op("min_int", 32'hCF000000, 0, 3'd0);
        run_op("two31", 32'h4F000000, 0, 3'd0);
        run_op("max_flt_int", 32'h4EFFFFFF, 0, 3'd0);
        run_op("u_m1", 32'hBF800000, 1, 3'd0);
        run_op("u_m03_rtz", 32'hBE99999A, 1, 3'd1);
        run_op("u_m03_rdn", 32'hBE99999A, 1, 3'd2);
        run_op("u_two32", 32'h4F800000, 1, 3'd0);
        run_op("nan_s", 32'h7FC00000, 0, 3'd0);
        run_op("nan_u", 32'h7FC00000, 1, 3'd0);
        run_op("ninf_s", 32'hFF800000, 0, 3'd0);
        run_op("subn_rup", 32'h00000001, 0, 3'd3);
        run_op("neg_zero", 32'h80000000, 0, 3'd0);
        run_op("rsvd_rm", 32'h3FC00000, 0, 3'd6);

        // Leave nonzero outputs behind, then kill during ALIGN.
        run_op("pre_kill", 32'h40200000, 0, 3'd3);
        @(negedge clk);
        float_in = 32'h41200000; op_cvtfi = 1; load = 1;
        @(negedge clk);
        load = 0; op_cvtfi = 0; kill = 1;
        @(negedge clk);
        kill = 0;
        check_cleared("kill_align");

        run_op("pre_rst", 32'hC1200000, 0, 3'd0);
        @(negedge clk);
        float_in = 32'h41200000; op_cvtfi = 1; load = 1;
        @(negedge clk);
        load = 0; op_cvtfi = 0;
        @(negedge clk);
        n_reset = 0;
        @(negedge clk);
        n_reset = 1;
        chk("rst_round_ready", {31'b0, ready}, 32'd0);
        check_cleared("rst_round");

        // Reload during ALIGN: only the second operand must come out.
        @(negedge clk);
        float_in = 32'h41200000; op_cvtfi = 1; rm = 0; load = 1;
        @(negedge clk);
        run_op("reload", 32'hC0200000, 0, 3'd2);

        @(negedge clk);
        load = 1; op_cvtfi = 0; op_cvtfu = 0;
        @(negedge clk);
        load = 0;
        chk("noop_load_ready", {31'b0, ready}, 32'd0);
        check_cleared("noop_load");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] f;
            f = $urandom;
            case ($urandom_range(0, 3))
                0: f[30:23] = 8'($urandom_range(120, 162));
                1: f[30:23] = 8'($urandom_range(150, 160));
                2: f[30:23] = 8'($urandom_range(124, 130));
                default: ;
            endcase
            if ($urandom_range(0, 15) == 0) f[22:0] = 0;
            run_op($sformatf("rnd%0d", i), f, 1'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/airi5c_ftoi_converter.md
Name: airi5c_ftoi_converter

Overview:
Multi-cycle FPU sub-unit that executes FCVT.W.S and FCVT.WU.S: converts an IEEE-754 single-precision operand to a signed or unsigned 32-bit integer under the RISC-V rounding mode. It is the counterpart of the int-to-float converter. It sits beside the other FPU sub-units and uses the same load/kill/ready handshake. It reports the invalid (NV) and inexact (NX) flags to the FPU flag accumulator.

Parameters:
none

Ports:
clk        input   1   clock, rising edge
n_reset    input   1   synchronous, active-low reset
kill       input   1   abort current operation; clears unit
load       input   1   start strobe; operands sampled at this edge
op_cvtfi   input   1   float to signed int (FCVT.W.S)
op_cvtfu   input   1   float to unsigned int (FCVT.WU.S)
rm         input   3   resolved rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
float_in   input   32  single-precision operand
int_out    output  32  integer result, registered
NV         output  1   invalid flag, registered
NX         output  1   inexact flag, registered
ready      output  1   one-cycle result strobe

Behaviour:
- Interface: one clock `clk`; reset `n_reset` is synchronous and active-low, sampled only on the rising edge of clk.
- Reset (n_reset=0 at an edge): int_out=0, NV=0, NX=0, ready=0, state=IDLE, all internal registers cleared. Reset overrides kill and load.
- Priority per edge: reset > kill > load > advance.
- kill, or load with neither op bit set: same clearing as reset (outputs 0, state IDLE).
- FSM states: IDLE -> ALIGN -> ROUND -> IDLE.
- load with a valid op (from any state): registers float_in, rm, and the signed/unsigned selection; state=ALIGN; ready=0. A load while busy restarts the unit and discards the old operation.
- ALIGN edge:
  - Classify the operand: NaN (exp=FF, man!=0), Inf, zero/subnormal (exp=00), normal.
  - Unbiased e = exp-127. Significand {1,man} is shifted to give a 32-bit integer magnitude, a round bit (first discarded bit) and a sticky bit (OR of the rest).
  - e<0: magnitude=0; round bit = (e==-1); sticky = remaining bits.
  - Zero/subnormal: magnitude=0, round=0, sticky=|man.
  - e>=32: pre-overflow flag set; no shift is performed.
  - state=ROUND.
- ROUND edge:
  - Increment decision from sign, rm, lsb, round bit and sticky. RNE: r&(s|lsb). RTZ: never. RDN: negative&(r|s). RUP: positive&(r|s). RMM: r. Reserved rm values behave as RNE.
  - Inexact = r|s.
  - Rounded magnitude is computed 33 bits wide.
  - Signed results:
    - positive: overflow if magnitude > 0x7FFFFFFF.
    - negative: overflow if magnitude > 0x80000000.
    - result = sign ? -magnitude : magnitude.
  - Unsigned results:
    - overflow if magnitude > 0xFFFFFFFF.
    - negative with rounded magnitude != 0: invalid, result 0.
    - negative with rounded magnitude 0: result 0; NX per inexact, NV=0.
  - Invalid cases and their results:
    - NaN: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned.
    - +Inf or positive overflow: 0x7FFFFFFF signed, 0xFFFFFFFF unsigned.
    - -Inf or negative overflow: 0x80000000 signed, 0x00000000 unsigned.
  - Flags: invalid -> NV=1, NX=0. Otherwise NV=0, NX=inexact.
  - Outputs are written, ready=1 for exactly this cycle, state=IDLE.
- Latency: load sampled at edge N -> ready high during the cycle after edge N+2. Throughput is one conversion per 3 cycles.
- int_out/NV/NX hold their values after ready drops until the next load, kill or reset. -0.0 gives 0 with no flags.

Test Plan:
- Signed rounding of 2.5: float_in=0x40200000, op_cvtfi. rm=RNE -> 0x00000002 NX=1. RUP -> 0x00000003 NX=1. RMM -> 0x00000003. RTZ -> 0x00000002. Each ready exactly 3 cycles after load, 1 cycle wide.
- Negative rounding: 0xC0200000 (-2.5). RDN -> 0xFFFFFFFD NX=1. RTZ -> 0xFFFFFFFE NX=1. 0xC1200000 (-10.0) RNE -> 0xFFFFFFF6 NX=0 NV=0.
- Signed boundaries: 0xCF000000 (-2^31) -> 0x80000000, no flags. 0x4F000000 (2^31) -> 0x7FFFFFFF NV=1. 0x4EFFFFFF RNE -> 0x7FFFFF80 no flags.
- Unsigned: op_cvtfu with 0xBF800000 (-1.0) -> 0 NV=1. 0xBE99999A (-0.3) RTZ -> 0 NX=1 NV=0; same operand with RDN -> 0 NV=1. 0x4F800000 (2^32) -> 0xFFFFFFFF NV=1.
- Specials: 0x7FC00000 NaN -> signed 0x7FFFFFFF NV, unsigned 0xFFFFFFFF NV. 0xFF800000 -> signed 0x80000000 NV. 0x00000001 subnormal RUP -> 1 NX. 0x80000000 -> 0, no flags.
- Control:
  - kill during ALIGN -> no ready pulse; outputs 0.
  - n_reset=0 during ROUND -> outputs 0 next edge; ready stays 0.
  - Second load during ALIGN -> only the second result is produced, 3 cycles after the second load.
  - load with no op bit -> outputs cleared, ready 0.
